// File: rtl/vending_pkg.sv
// Shared types, constants and helpers for the vending controller.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_e;

  localparam int DEF_N_ITEMS  = 5;
  localparam int DEF_CREDIT_W = 8;
  localparam int SEL_W        = $clog2(DEF_N_ITEMS + 1);
  localparam int CREDIT_MAX   = (1 << DEF_CREDIT_W) - 1;

  // Widest packed price list any instance may pass in.
  localparam int PL_MAX_W = 256;

  // Brings the price of item idx (1-based) down to bit 0; the caller truncates
  // to its own credit width. Index 0 ("no item") yields a zero price.
  function automatic logic [PL_MAX_W-1:0] price_shift(input logic [PL_MAX_W-1:0] list,
                                                      input int unsigned          idx,
                                                      input int unsigned          width);
    if (idx == 0) return '0;
    return list >> ((idx - 1) * width);
  endfunction

endpackage

// File: rtl/vending_stock.sv
// Per-item stock counters with a bulk reload and a single decrement port.
module vending_stock
  import vending_pkg::*;
#(
  parameter int N_ITEMS    = 5,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 3,
  parameter int IDX_W      = $clog2(N_ITEMS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               restock_i,
  input  logic               dec_en_i,
  input  logic [IDX_W-1:0]   dec_idx_i,
  input  logic [IDX_W-1:0]   rd_idx_i,
  output logic [STOCK_W-1:0] count_o
);

  logic [STOCK_W-1:0] stock_q [1:N_ITEMS];

  // Reload all counters on restock, otherwise decrement the vended item.
  // NOTE: this array is reset (unlike a RAM) because reset must restore a known stock level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= N_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      for (int i = 1; i <= N_ITEMS; i++) begin
        if (restock_i) begin
          stock_q[i] <= STOCK_W'(STOCK_INIT);
        end else if (dec_en_i && (dec_idx_i == IDX_W'(i)) && (stock_q[i] != '0)) begin
          stock_q[i] <= stock_q[i] - STOCK_W'(1);
        end
      end
    end
  end

  // Read the counter at the requested index; out-of-range indices read as empty.
  always_comb begin
    count_o = '0;
    for (int i = 1; i <= N_ITEMS; i++) begin
      if (rd_idx_i == IDX_W'(i)) count_o = stock_q[i];
    end
  end

endmodule

// File: rtl/vending_fsm.sv
// Moore vending controller: credit accumulation, selection, price/stock check,
// one-cycle vend and one-cycle change return.
module vending_fsm
  import vending_pkg::*;
#(
  parameter int                            N_ITEMS    = 5,
  parameter int                            CREDIT_W   = 8,
  parameter logic [N_ITEMS*CREDIT_W-1:0]   PRICE_LIST = 40'h19_140F_0A05,
  parameter int                            STOCK_W    = 4,
  parameter int                            STOCK_INIT = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              coin_valid,
  input  logic [CREDIT_W-1:0]               coin_val,
  input  logic                              switch,
  input  logic                              buy,
  input  logic                              cancel,
  input  logic                              restock,
  output logic [$clog2(N_ITEMS+1)-1:0]      sel,
  output logic [CREDIT_W-1:0]               credit,
  output logic [$clog2(N_ITEMS+1)-1:0]      drink,
  output logic                              drink_valid,
  output logic [CREDIT_W-1:0]               change,
  output logic                              change_valid,
  output logic                              coin_reject,
  output logic                              deny,
  output logic                              sold_out
);

  localparam int SEL_BITS = $clog2(N_ITEMS + 1);

  state_e                state_q, state_d;
  logic [SEL_BITS-1:0]   sel_q, sel_d;
  logic [SEL_BITS-1:0]   vend_idx_q, vend_idx_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic                  coin_reject_q, coin_reject_d;
  logic                  deny_q, deny_d;

  logic [CREDIT_W-1:0]   price_sel;
  logic [CREDIT_W-1:0]   price_vend;
  logic [CREDIT_W:0]     coin_sum;
  logic [STOCK_W-1:0]    stock_sel;
  logic                  buy_ok;
  logic                  restock_en;
  logic                  dec_en;

  // Prices of the displayed selection (for the buy check) and of the item
  // being vended (latched at buy so a later switch cannot change the charge).
  assign price_sel  = CREDIT_W'(price_shift(PL_MAX_W'(PRICE_LIST), 32'(sel_q), CREDIT_W));
  assign price_vend = CREDIT_W'(price_shift(PL_MAX_W'(PRICE_LIST), 32'(vend_idx_q), CREDIT_W));

  // Extra top bit is the carry: set means the coin would overflow the credit.
  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_val};
  assign buy_ok   = (credit_q >= price_sel) && (stock_sel != '0);

  vending_stock #(
    .N_ITEMS    (N_ITEMS),
    .STOCK_W    (STOCK_W),
    .STOCK_INIT (STOCK_INIT),
    .IDX_W      (SEL_BITS)
  ) u_stock (
    .clk       (clk),
    .rst       (rst),
    .restock_i (restock_en),
    .dec_en_i  (dec_en),
    .dec_idx_i (vend_idx_q),
    .rd_idx_i  (sel_q),
    .count_o   (stock_sel)
  );

  // State, selection, credit and pulse registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sel_q         <= SEL_BITS'(1);
      vend_idx_q    <= SEL_BITS'(1);
      credit_q      <= '0;
      coin_reject_q <= 1'b0;
      deny_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      vend_idx_q    <= vend_idx_d;
      credit_q      <= credit_d;
      coin_reject_q <= coin_reject_d;
      deny_q        <= deny_d;
    end
  end

  // Next-state and datapath control.
  // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    vend_idx_d    = vend_idx_q;
    credit_d      = credit_q;
    coin_reject_d = 1'b0;
    deny_d        = 1'b0;
    restock_en    = 1'b0;
    dec_en        = 1'b0;

    unique case (state_q)
      IDLE, CREDIT: begin
        if (switch) begin
          sel_d = (sel_q == SEL_BITS'(N_ITEMS)) ? SEL_BITS'(1) : sel_q + SEL_BITS'(1);
        end
        if (coin_valid) begin
          if (coin_sum[CREDIT_W]) coin_reject_d = 1'b1;
          else                    credit_d      = coin_sum[CREDIT_W-1:0];
        end
        restock_en = restock;
        state_d    = (credit_d != '0) ? CREDIT : IDLE;

        // Cancel outranks buy; in IDLE it simply swallows the buy.
        if (cancel) begin
          if (state_q == CREDIT) state_d = CHANGE;
        end else if (buy) begin
          if (buy_ok) begin
            state_d    = VEND;
            vend_idx_d = sel_q;
          end else begin
            deny_d = 1'b1;
          end
        end
      end

      VEND: begin
        dec_en        = 1'b1;
        credit_d      = credit_q - price_vend;
        state_d       = (credit_d != '0) ? CHANGE : IDLE;
        coin_reject_d = coin_valid;
      end

      CHANGE: begin
        credit_d      = '0;
        state_d       = IDLE;
        coin_reject_d = coin_valid;
      end

      default: state_d = IDLE;
    endcase
  end

  // Moore outputs: registers or decodes of the current state.
  assign sel          = sel_q;
  assign credit       = credit_q;
  assign drink_valid  = (state_q == VEND);
  assign drink        = drink_valid ? vend_idx_q : '0;
  assign change_valid = (state_q == CHANGE);
  assign change       = change_valid ? credit_q : '0;
  assign coin_reject  = coin_reject_q;
  assign deny         = deny_q;
  assign sold_out     = (stock_sel == '0);

endmodule

// File: tb/tb_vending_fsm.sv
// Directed self-checking bench for vending_fsm with default parameters.
module tb_vending_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [7:0] coin_val = '0;
  logic       switch = 1'b0;
  logic       buy = 1'b0;
  logic       cancel = 1'b0;
  logic       restock = 1'b0;
  logic [2:0] sel;
  logic [7:0] credit;
  logic [2:0] drink;
  logic       drink_valid;
  logic [7:0] change;
  logic       change_valid;
  logic       coin_reject;
  logic       deny;
  logic       sold_out;

  int n_cmp = 0;
  int n_err = 0;

  vending_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .coin_valid   (coin_valid),
    .coin_val     (coin_val),
    .switch       (switch),
    .buy          (buy),
    .cancel       (cancel),
    .restock      (restock),
    .sel          (sel),
    .credit       (credit),
    .drink        (drink),
    .drink_valid  (drink_valid),
    .change       (change),
    .change_valid (change_valid),
    .coin_reject  (coin_reject),
    .deny         (deny),
    .sold_out     (sold_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [7:0] v);
    coin_valid = 1'b1; coin_val = v;
    step();
    coin_valid = 1'b0; coin_val = '0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_sel", sel, 1);
    check("rst_credit", credit, 0);
    check("rst_drink", drink, 0);
    check("rst_dv", drink_valid, 0);
    check("rst_cv", change_valid, 0);
    check("rst_sold", sold_out, 0);

    // Selection walk with wrap
    begin
      int exp_sel [6] = '{2, 3, 4, 5, 1, 2};
      switch = 1'b1;
      for (int i = 0; i < 6; i++) begin
        step();
        check($sformatf("walk_sel%0d", i), sel, exp_sel[i]);
      end
      switch = 1'b0;
      check("walk_drink", drink, 0);
      check("walk_credit", credit, 0);
    end

    // Buy item 3 (price 15) with 20, get 5 change
    switch = 1'b1; step(); switch = 1'b0;
    check("i3_sel", sel, 3);
    coin(8'd10);
    check("i3_c1", credit, 10);
    coin(8'd10);
    check("i3_c2", credit, 20);
    buy = 1'b1; step(); buy = 1'b0;
    check("i3_dv", drink_valid, 1);
    check("i3_drink", drink, 3);
    step();
    check("i3_cv", change_valid, 1);
    check("i3_change", change, 5);
    check("i3_stock", dut.u_stock.stock_q[3], 2);
    check("i3_dv_off", drink_valid, 0);
    step();
    check("i3_idle_credit", credit, 0);
    check("i3_idle_cv", change_valid, 0);

    // Item 5 (price 25) with 20 denied, then cancel refunds
    switch = 1'b1; step(); step(); switch = 1'b0;
    check("i5_sel", sel, 5);
    coin(8'd10); coin(8'd10);
    buy = 1'b1; step(); buy = 1'b0;
    check("i5_deny", deny, 1);
    check("i5_dv", drink_valid, 0);
    check("i5_credit", credit, 20);
    cancel = 1'b1; step(); cancel = 1'b0;
    check("i5_deny_off", deny, 0);
    check("i5_cv", change_valid, 1);
    check("i5_change", change, 20);
    step();
    check("i5_idle", credit, 0);

    // Exhaust item 1 (price 5) with exact credit
    switch = 1'b1; step(); switch = 1'b0;
    check("i1_sel", sel, 1);
    for (int k = 0; k < 3; k++) begin
      coin(8'd5);
      buy = 1'b1; step(); buy = 1'b0;
      check($sformatf("i1_drink%0d", k), drink, 1);
      step();
      check($sformatf("i1_nochg%0d", k), change_valid, 0);
      check($sformatf("i1_credit%0d", k), credit, 0);
    end
    check("i1_sold", sold_out, 1);
    coin(8'd5);
    buy = 1'b1; step(); buy = 1'b0;
    check("i1_deny", deny, 1);
    check("i1_deny_dv", drink_valid, 0);
    restock = 1'b1; step(); restock = 1'b0;
    check("i1_restock_sold", sold_out, 0);
    check("i1_restock_cnt", dut.u_stock.stock_q[1], 3);
    buy = 1'b1; step(); buy = 1'b0;
    check("i1_rebuy_dv", drink_valid, 1);
    check("i1_rebuy_drink", drink, 1);
    step();
    check("i1_rebuy_cnt", dut.u_stock.stock_q[1], 2);
    check("i1_rebuy_credit", credit, 0);

    // Credit overflow boundary and coin during VEND
    coin(8'd250);
    check("ov_credit250", credit, 250);
    coin(8'd10);
    check("ov_reject", coin_reject, 1);
    check("ov_credit_hold", credit, 250);
    coin(8'd5);
    check("ov_reject_off", coin_reject, 0);
    check("ov_credit255", credit, 255);
    buy = 1'b1; step(); buy = 1'b0;
    check("ov_vend", drink_valid, 1);
    coin(8'd5);
    check("ov_vend_reject", coin_reject, 1);
    check("ov_change", change, 250);
    step();
    check("ov_idle", credit, 0);

    // Buy and cancel together: cancel wins
    coin(8'd10);
    buy = 1'b1; cancel = 1'b1; step(); buy = 1'b0; cancel = 1'b0;
    check("bc_cv", change_valid, 1);
    check("bc_change", change, 10);
    check("bc_dv", drink_valid, 0);
    check("bc_deny", deny, 0);
    step();

    // Reset during VEND loses the decrement and the credit
    coin(8'd5);
    buy = 1'b1; step(); buy = 1'b0;
    check("rv_in_vend", drink_valid, 1);
    rst = 1'b1;
    #1;
    check("rv_dv", drink_valid, 0);
    check("rv_drink", drink, 0);
    check("rv_credit", credit, 0);
    check("rv_sel", sel, 1);
    check("rv_stock", dut.u_stock.stock_q[1], 3);
    step();
    rst = 1'b0;
    step();
    check("rv_after_credit", credit, 0);
    check("rv_after_cv", change_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
